// File: rtl/stack_ctrl.sv
// ---------------------------------------------------------------------------
// stack_ctrl
//   Sequencer/arbiter for the return-address stack. Serves one CALL, RET,
//   RETI or IRQ-entry request at a time, drives the stack push/pop strobes,
//   the PC load path and the pipeline stall, and keeps a shadow copy of the
//   stack depth so that overflow/underflow never reach the stack itself.
//
// Ports
//   clk, reset          rising-edge clock, synchronous active-high reset
//   call_req, ret_req,  decoder requests, held until ack
//   reti_req
//   irq_req             interrupt request level
//   call_target         CALL destination
//   pc_ret              return address to push (PC+1)
//   stack_out           stack read data, valid the cycle after stack_read
//   stack_read/write    pop / push strobes to the stack
//   stack_pc            push data to the stack
//   pc_load, pc_next    PC load strobe and new PC value
//   ack, irq_ack        one-cycle completion pulses
//   stall               freeze fetch/decode
//   in_isr              interrupt being serviced, further IRQs masked
//   level               current stack depth (0..DEPTH)
//   fault               sticky overflow/underflow/bad-RETI flag
// ---------------------------------------------------------------------------
module stack_ctrl #(
  parameter int              PC_W     = 13,
  parameter int              DEPTH    = 8,
  parameter int              LVL_W    = 4,
  parameter logic [PC_W-1:0] VEC_ADDR = 'h0004
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             call_req,
  input  logic             ret_req,
  input  logic             reti_req,
  input  logic             irq_req,
  input  logic [PC_W-1:0]  call_target,
  input  logic [PC_W-1:0]  pc_ret,
  input  logic [PC_W-1:0]  stack_out,
  output logic             stack_read,
  output logic             stack_write,
  output logic [PC_W-1:0]  stack_pc,
  output logic             pc_load,
  output logic [PC_W-1:0]  pc_next,
  output logic             ack,
  output logic             irq_ack,
  output logic             stall,
  output logic             in_isr,
  output logic [LVL_W-1:0] level,
  output logic             fault
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_PUSH,
    S_POP,
    S_POPW,
    S_FAULT
  } state_t;

  state_t           state_q;
  logic             stack_read_q;
  logic             stack_write_q;
  logic [PC_W-1:0]  stack_pc_q;
  logic             pc_load_q;
  logic [PC_W-1:0]  pc_next_q;
  logic             ack_q;
  logic             irq_ack_q;
  logic             in_isr_q;
  logic [LVL_W-1:0] level_q;
  logic             fault_q;
  // Remembers whether the operation in flight is IRQ entry (PUSH) or RETI (POPW),
  // so in_isr can be updated when that operation completes.
  logic             isr_op_q;

  // Arbitration (fixed priority) and legality of the winning request.
  logic             irq_go;
  logic             reti_go;
  logic             ret_go;
  logic             call_go;
  logic             push_go;
  logic             req_any;
  logic             full;
  logic             empty;
  logic             bad;
  logic [LVL_W-1:0] level_inc_d;
  logic [LVL_W-1:0] level_dec_d;

  always_comb begin
    irq_go      = irq_req & ~in_isr_q;
    reti_go     = ~irq_go & reti_req;
    ret_go      = ~irq_go & ~reti_req & ret_req;
    call_go     = ~irq_go & ~reti_req & ~ret_req & call_req;
    push_go     = irq_go | call_go;
    req_any     = irq_go | reti_req | ret_req | call_req;
    full        = (level_q == LVL_W'(DEPTH));
    empty       = (level_q == '0);
    // Overflow, underflow and RETI outside an ISR all trap into FAULT.
    bad         = (push_go & full) | ((reti_go | ret_go) & empty) | (reti_go & ~in_isr_q);
    level_inc_d = level_q + 1'b1;
    level_dec_d = level_q - 1'b1;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= S_IDLE;
      stack_read_q  <= 1'b0;
      stack_write_q <= 1'b0;
      stack_pc_q    <= '0;
      pc_load_q     <= 1'b0;
      pc_next_q     <= '0;
      ack_q         <= 1'b0;
      irq_ack_q     <= 1'b0;
      in_isr_q      <= 1'b0;
      level_q       <= '0;
      fault_q       <= 1'b0;
      isr_op_q      <= 1'b0;
    end else begin
      // Strobes and acks are single-cycle pulses; each state below raises the
      // ones belonging to the state it is about to enter.
      stack_read_q  <= 1'b0;
      stack_write_q <= 1'b0;
      pc_load_q     <= 1'b0;
      ack_q         <= 1'b0;
      irq_ack_q     <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (req_any) begin
            if (bad) begin
              fault_q <= 1'b1;
              state_q <= S_FAULT;
            end else if (push_go) begin
              stack_write_q <= 1'b1;
              stack_pc_q    <= pc_ret;
              pc_load_q     <= 1'b1;
              pc_next_q     <= irq_go ? VEC_ADDR : call_target;
              ack_q         <= call_go;
              irq_ack_q     <= irq_go;
              isr_op_q      <= irq_go;
              level_q       <= level_inc_d;
              state_q       <= S_PUSH;
            end else begin
              stack_read_q <= 1'b1;
              isr_op_q     <= reti_go;
              level_q      <= level_dec_d;
              state_q      <= S_POP;
            end
          end
        end
        S_PUSH: begin
          if (isr_op_q) in_isr_q <= 1'b1;
          state_q <= S_IDLE;
        end
        S_POP: begin
          pc_load_q <= 1'b1;
          ack_q     <= 1'b1;
          state_q   <= S_POPW;
        end
        S_POPW: begin
          if (isr_op_q) in_isr_q <= 1'b0;
          state_q <= S_IDLE;
        end
        S_FAULT: begin
          state_q <= S_FAULT;
        end
        default: begin
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign stack_read  = stack_read_q;
  assign stack_write = stack_write_q;
  assign stack_pc    = stack_pc_q;
  assign pc_load     = pc_load_q;
  // Popped data only arrives during POPW, so it is forwarded straight through.
  assign pc_next     = (state_q == S_POPW) ? stack_out : pc_next_q;
  assign ack         = ack_q;
  assign irq_ack     = irq_ack_q;
  assign stall       = (state_q != S_IDLE) | req_any;
  assign in_isr      = in_isr_q;
  assign level       = level_q;
  assign fault       = fault_q;

endmodule

// File: tb/tb_stack_ctrl.sv
module tb_stack_ctrl;
  localparam int PC_W  = 13;
  localparam int DEPTH = 8;
  localparam int LVL_W = 4;
  localparam logic [PC_W-1:0] VEC = 13'h0004;

  logic             clk = 1'b0;
  logic             reset = 1'b1;
  logic             call_req = 1'b0, ret_req = 1'b0, reti_req = 1'b0, irq_req = 1'b0;
  logic [PC_W-1:0]  call_target = '0, pc_ret = '0;
  logic [PC_W-1:0]  stack_out = '0;
  logic             stack_read, stack_write, pc_load, ack, irq_ack, stall, in_isr, fault;
  logic [PC_W-1:0]  stack_pc, pc_next;
  logic [LVL_W-1:0] level;

  always #5 clk = ~clk;

  stack_ctrl #(.PC_W(PC_W), .DEPTH(DEPTH), .LVL_W(LVL_W), .VEC_ADDR(VEC)) dut (
    .clk(clk), .reset(reset), .call_req(call_req), .ret_req(ret_req),
    .reti_req(reti_req), .irq_req(irq_req), .call_target(call_target),
    .pc_ret(pc_ret), .stack_out(stack_out), .stack_read(stack_read),
    .stack_write(stack_write), .stack_pc(stack_pc), .pc_load(pc_load),
    .pc_next(pc_next), .ack(ack), .irq_ack(irq_ack), .stall(stall),
    .in_isr(in_isr), .level(level), .fault(fault)
  );

  // ---------------- stack memory attached to the DUT ----------------
  logic [PC_W-1:0] smem [DEPTH];
  int sp = 0;
  always @(posedge clk) begin
    if (reset) sp <= 0;
    else if (stack_write && sp < DEPTH) begin
      smem[sp] <= stack_pc;
      sp <= sp + 1;
    end else if (stack_read && sp > 0) begin
      stack_out <= smem[sp-1];
      sp <= sp - 1;
    end
  end

  // ---------------- transaction-level reference model ----------------
  typedef enum logic [2:0] {M_NONE, M_CALL, M_IRQ, M_RET, M_RETI} op_e;
  op_e             m_op = M_NONE;   // operation in progress
  int              m_step = 0;      // 1 = first cycle after accept, 2 = second
  int              m_level = 0;
  bit              m_isr = 1'b0, m_fault = 1'b0;
  logic [PC_W-1:0] m_q[$];          // return addresses currently on the stack
  logic [PC_W-1:0] m_ra = '0, m_tgt = '0, m_pop = '0;
  op_e             m_sel;
  assign m_sel = (irq_req && !m_isr) ? M_IRQ : reti_req ? M_RETI :
                 ret_req ? M_RET : call_req ? M_CALL : M_NONE;

  always @(posedge clk) begin
    if (reset) begin
      m_op <= M_NONE; m_step <= 0; m_level <= 0; m_isr <= 1'b0; m_fault <= 1'b0;
      m_q.delete();
    end else if (m_fault) begin
      m_step <= 0;
    end else if (m_op == M_NONE) begin
      if (m_sel == M_IRQ || m_sel == M_CALL) begin
        if (m_level == DEPTH) m_fault <= 1'b1;
        else begin
          m_q.push_back(pc_ret);
          m_ra    <= pc_ret;
          m_tgt   <= (m_sel == M_IRQ) ? VEC : call_target;
          m_level <= m_level + 1;
          m_op    <= m_sel;
          m_step  <= 1;
        end
      end else if (m_sel == M_RET || m_sel == M_RETI) begin
        if (m_level == 0 || (m_sel == M_RETI && !m_isr)) m_fault <= 1'b1;
        else begin
          m_pop <= m_q[$];
          void'(m_q.pop_back());
          m_level <= m_level - 1;
          m_op    <= m_sel;
          m_step  <= 1;
        end
      end
    end else if (m_op == M_CALL || m_op == M_IRQ) begin
      if (m_op == M_IRQ) m_isr <= 1'b1;
      m_op <= M_NONE; m_step <= 0;
    end else if (m_step == 1) begin
      m_step <= 2;
    end else begin
      if (m_op == M_RETI) m_isr <= 1'b0;
      m_op <= M_NONE; m_step <= 0;
    end
  end

  // expected outputs for the current cycle
  logic e_push, e_pop, e_wr, e_rd, e_ld, e_ack, e_iack, e_stall;
  assign e_push  = (m_op == M_CALL) || (m_op == M_IRQ);
  assign e_pop   = (m_op == M_RET) || (m_op == M_RETI);
  assign e_wr    = e_push;
  assign e_rd    = e_pop && m_step == 1;
  assign e_ld    = e_wr || (e_pop && m_step == 2);
  assign e_ack   = (m_op == M_CALL) || (e_pop && m_step == 2);
  assign e_iack  = (m_op == M_IRQ);
  assign e_stall = m_fault || (m_op != M_NONE) || (irq_req && !m_isr) ||
                   reti_req || ret_req || call_req;

  // ---------------- hand-computed literal expectations ----------------
  localparam int L_WR = 0, L_RD = 1, L_SPC = 2, L_LD = 3, L_PCN = 4, L_ACK = 5,
                 L_IACK = 6, L_STALL = 7, L_ISR = 8, L_LVL = 9, L_FLT = 10;
  typedef struct { string nm; int id; logic [31:0] v; } lit_t;
  lit_t lit_q[$];

  task automatic lit(input string nm, input int id, input int v);
    lit_q.push_back('{nm, id, 32'(v)});
  endtask

  function automatic logic [31:0] get_sig(input int id);
    case (id)
      L_WR:    return 32'(stack_write);
      L_RD:    return 32'(stack_read);
      L_SPC:   return 32'(stack_pc);
      L_LD:    return 32'(pc_load);
      L_PCN:   return 32'(pc_next);
      L_ACK:   return 32'(ack);
      L_IACK:  return 32'(irq_ack);
      L_STALL: return 32'(stall);
      L_ISR:   return 32'(in_isr);
      L_LVL:   return 32'(level);
      default: return 32'(fault);
    endcase
  endfunction

  // ---------------- single compare process ----------------
  int  n_vec = 0, n_err = 0;
  bit  chk_en = 1'b0;
  op_e dr_op = M_NONE;   // request the requester must drop after the next edge

  task automatic cmp(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s at %0t: got 0x%0h expected 0x%0h", nm, $time, act, exp);
    end
  endtask

  always @(negedge clk) begin
    dr_op <= (e_ack || e_iack) ? m_op : M_NONE;
    if (chk_en) begin
      cmp("stack_write", 32'(stack_write), 32'(e_wr));
      cmp("stack_read",  32'(stack_read),  32'(e_rd));
      cmp("pc_load",     32'(pc_load),     32'(e_ld));
      if (e_ld) cmp("pc_next", 32'(pc_next), 32'(e_wr ? m_tgt : m_pop));
      if (e_wr) cmp("stack_pc", 32'(stack_pc), 32'(m_ra));
      cmp("ack",         32'(ack),         32'(e_ack));
      cmp("irq_ack",     32'(irq_ack),     32'(e_iack));
      cmp("stall",       32'(stall),       32'(e_stall));
      cmp("in_isr",      32'(in_isr),      32'(m_isr));
      cmp("level",       32'(level),       32'(m_level));
      cmp("fault",       32'(fault),       32'(m_fault));
      while (lit_q.size() > 0) begin
        cmp(lit_q[0].nm, get_sig(lit_q[0].id), lit_q[0].v);
        void'(lit_q.pop_front());
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic tick();
    @(posedge clk);
    #1;
    case (dr_op)
      M_CALL:  call_req = 1'b0;
      M_IRQ:   irq_req  = 1'b0;
      M_RET:   ret_req  = 1'b0;
      M_RETI:  reti_req = 1'b0;
      default: ;
    endcase
  endtask

  task automatic do_reset();
    reset = 1'b1;
    call_req = 1'b0; ret_req = 1'b0; reti_req = 1'b0; irq_req = 1'b0;
    tick();
    reset = 1'b0;
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1);
  end

  initial begin
    tick(); tick();
    reset = 1'b0;
    chk_en = 1'b1;
    lit("rst_pc_next", L_PCN, 0); lit("rst_stack_pc", L_SPC, 0); lit("rst_level", L_LVL, 0);

    // CALL then RET
    call_target = 13'h0100; pc_ret = 13'h0011; call_req = 1'b1;
    tick();
    lit("t1_wr", L_WR, 1); lit("t1_spc", L_SPC, 'h11); lit("t1_ld", L_LD, 1);
    lit("t1_pcn", L_PCN, 'h100); lit("t1_ack", L_ACK, 1); lit("t1_lvl", L_LVL, 1);
    tick();
    ret_req = 1'b1;
    tick();
    lit("t2_rd", L_RD, 1); lit("t2_lvl", L_LVL, 0);
    tick();
    lit("t2_ld", L_LD, 1); lit("t2_pcn", L_PCN, 'h11); lit("t2_ack", L_ACK, 1);
    tick();

    // fill to DEPTH, then overflow
    for (int i = 0; i < DEPTH; i++) begin
      pc_ret = PC_W'(i + 'h40); call_target = PC_W'(i + 'h80); call_req = 1'b1;
      tick(); tick();
    end
    lit("t3_lvl8", L_LVL, 8);
    call_req = 1'b1;
    tick();
    lit("t3_nowr", L_WR, 0); lit("t3_flt", L_FLT, 1); lit("t3_stall", L_STALL, 1);
    tick();
    lit("t3_stall2", L_STALL, 1);
    do_reset();
    lit("t3_flt_clr", L_FLT, 0); lit("t3_lvl0", L_LVL, 0);

    // underflow and RETI outside ISR
    ret_req = 1'b1;
    tick();
    lit("t4_nord", L_RD, 0); lit("t4_flt", L_FLT, 1);
    do_reset();
    reti_req = 1'b1;
    tick();
    lit("t4_reti_flt", L_FLT, 1);
    do_reset();

    // IRQ beats CALL, masking, RETI
    pc_ret = 13'h0020; call_target = 13'h0200; irq_req = 1'b1; call_req = 1'b1;
    tick();
    lit("t5_iack", L_IACK, 1); lit("t5_pcn", L_PCN, 4); lit("t5_noack", L_ACK, 0);
    tick();
    lit("t5_isr", L_ISR, 1);
    tick();
    lit("t5_call_ack", L_ACK, 1); lit("t5_call_pcn", L_PCN, 'h200); lit("t5_lvl2", L_LVL, 2);
    tick();
    irq_req = 1'b1;
    lit("t5_masked_stall", L_STALL, 0);
    tick();
    lit("t5_masked_iack", L_IACK, 0); lit("t5_masked_lvl", L_LVL, 2);
    irq_req = 1'b0; reti_req = 1'b1;
    tick();
    lit("t5_reti_rd", L_RD, 1);
    tick();
    lit("t5_reti_ack", L_ACK, 1); lit("t5_reti_pcn", L_PCN, 'h20);
    tick();
    lit("t5_isr_clr", L_ISR, 0); lit("t5_lvl1", L_LVL, 1);

    // reset during POP
    do_reset();
    call_req = 1'b1;
    tick(); tick();
    ret_req = 1'b1;
    tick();
    lit("t6_rd", L_RD, 1);
    reset = 1'b1; ret_req = 1'b0;
    tick();
    reset = 1'b0;
    lit("t6_ld", L_LD, 0); lit("t6_ack", L_ACK, 0); lit("t6_lvl", L_LVL, 0); lit("t6_isr", L_ISR, 0);
    tick();

    // randomized traffic
    for (int c = 0; c < 4000; c++) begin
      pc_ret = PC_W'($urandom);
      call_target = PC_W'($urandom);
      if (reset) reset = 1'b0;
      else if ((m_fault && $urandom_range(0, 3) == 0) || $urandom_range(0, 199) == 0) begin
        reset = 1'b1;
        call_req = 1'b0; ret_req = 1'b0; reti_req = 1'b0; irq_req = 1'b0;
      end else begin
        if (!call_req && $urandom_range(0, 9) < 3) call_req = 1'b1;
        if (!ret_req && $urandom_range(0, 99) < ((m_level > 0) ? 20 : 2)) ret_req = 1'b1;
        if (!reti_req && $urandom_range(0, 99) < (m_isr ? 15 : 1)) reti_req = 1'b1;
        if (!irq_req && $urandom_range(0, 99) < 6) irq_req = 1'b1;
      end
      tick();
    end
    reset = 1'b0;
    tick();
    @(negedge clk);
    #1;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
